// File: rtl/video_timing_gen.sv
// Raster timing and test-pattern source for the LVDS transmitter's parallel video inputs.
// Every output is registered from the same decode, so all video signals leave with identical latency.
module video_timing_gen #(
    parameter int   H_ACTIVE = 800,
    parameter int   H_FP     = 40,
    parameter int   H_SYNC   = 128,
    parameter int   H_BP     = 88,
    parameter int   V_ACTIVE = 600,
    parameter int   V_FP     = 1,
    parameter int   V_SYNC   = 4,
    parameter int   V_BP     = 23,
    parameter logic HS_POL   = 1'b1,
    parameter logic VS_POL   = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [1:0] pattern_sel,
    output logic       HSync,
    output logic       VSync,
    output logic       DataEnable,
    output logic [7:0] Red,
    output logic [7:0] Green,
    output logic [7:0] Blue,
    output logic       frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
    localparam logic [10:0] V_LAST   = 11'(V_TOTAL - 1);
    localparam logic [10:0] H_ACT    = 11'(H_ACTIVE);
    localparam logic [10:0] V_ACT    = 11'(V_ACTIVE);
    localparam logic [10:0] HS_START = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HS_END   = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] VS_START = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] VS_END   = 11'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [10:0] BAR_LAST = 11'(H_ACTIVE / 8 - 1);

    // Raster position and pattern state
    logic [10:0] h_q, h_d, v_q, v_d;
    logic [10:0] bar_cnt_q, bar_cnt_d;
    logic [2:0]  bar_idx_q, bar_idx_d;
    logic [1:0]  pat_q, pat_d;

    // Registered video outputs
    logic        hs_q, hs_d, vs_q, vs_d, de_q, de_d, fs_q, fs_d;
    logic [23:0] rgb_q, rgb_d;

    logic        h_wrap, v_wrap, origin, active, hs, vs;
    logic [1:0]  pat_cur;
    logic [23:0] pix;

    always_comb begin
        h_wrap  = (h_q == H_LAST);
        v_wrap  = (v_q == V_LAST);
        origin  = (h_q == 11'd0) && (v_q == 11'd0);
        active  = (h_q < H_ACT) && (v_q < V_ACT);
        hs      = (h_q >= HS_START) && (h_q < HS_END);
        vs      = (v_q >= VS_START) && (v_q < VS_END);
        // The origin pixel already belongs to the frame whose pattern is being captured.
        pat_cur = origin ? pattern_sel : pat_q;

        pix = 24'h000000;
        unique case (pat_cur)
            2'b00: begin
                unique case (bar_idx_q)
                    3'd0: pix = 24'hFFFFFF;
                    3'd1: pix = 24'hFFFF00;
                    3'd2: pix = 24'h00FFFF;
                    3'd3: pix = 24'h00FF00;
                    3'd4: pix = 24'hFF00FF;
                    3'd5: pix = 24'hFF0000;
                    3'd6: pix = 24'h0000FF;
                    default: pix = 24'h000000;
                endcase
            end
            2'b01: pix = {3{h_q[7:0]}};
            2'b10: pix = (h_q[5] ^ v_q[5]) ? 24'hFFFFFF : 24'h000000;
            default: pix = ((h_q[4:0] == 5'd0) || (v_q[4:0] == 5'd0)) ? 24'hFFFFFF : 24'h000000;
        endcase
    end

    always_comb begin
        h_d       = h_q;
        v_d       = v_q;
        bar_cnt_d = bar_cnt_q;
        bar_idx_d = bar_idx_q;
        pat_d     = pat_q;
        hs_d      = ~HS_POL;
        vs_d      = ~VS_POL;
        de_d      = 1'b0;
        fs_d      = 1'b0;
        rgb_d     = 24'h000000;

        if (!en) begin
            h_d       = 11'd0;
            v_d       = 11'd0;
            bar_cnt_d = 11'd0;
            bar_idx_d = 3'd0;
        end else begin
            hs_d  = hs ? HS_POL : ~HS_POL;
            vs_d  = vs ? VS_POL : ~VS_POL;
            de_d  = active;
            fs_d  = origin;
            rgb_d = active ? pix : 24'h000000;
            if (origin)
                pat_d = pattern_sel;

            if (h_wrap) begin
                h_d       = 11'd0;
                bar_cnt_d = 11'd0;
                bar_idx_d = 3'd0;
                v_d       = v_wrap ? 11'd0 : v_q + 11'd1;
            end else begin
                h_d = h_q + 11'd1;
                // Bar index walks with h; past the active region its value is never shown.
                if (bar_cnt_q == BAR_LAST) begin
                    bar_cnt_d = 11'd0;
                    bar_idx_d = bar_idx_q + 3'd1;
                end else begin
                    bar_cnt_d = bar_cnt_q + 11'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h_q       <= 11'd0;
            v_q       <= 11'd0;
            bar_cnt_q <= 11'd0;
            bar_idx_q <= 3'd0;
            pat_q     <= 2'b00;
            hs_q      <= ~HS_POL;
            vs_q      <= ~VS_POL;
            de_q      <= 1'b0;
            fs_q      <= 1'b0;
            rgb_q     <= 24'h000000;
        end else begin
            h_q       <= h_d;
            v_q       <= v_d;
            bar_cnt_q <= bar_cnt_d;
            bar_idx_q <= bar_idx_d;
            pat_q     <= pat_d;
            hs_q      <= hs_d;
            vs_q      <= vs_d;
            de_q      <= de_d;
            fs_q      <= fs_d;
            rgb_q     <= rgb_d;
        end
    end

    assign HSync       = hs_q;
    assign VSync       = vs_q;
    assign DataEnable  = de_q;
    assign frame_start = fs_q;
    assign Red         = rgb_q[23:16];
    assign Green       = rgb_q[15:8];
    assign Blue        = rgb_q[7:0];

endmodule

// File: tb/tb_video_timing_gen.sv
// Directed bench for video_timing_gen on a 24x7 raster; a second instance runs with inverted sync polarity.
module tb_video_timing_gen;

    localparam int HT = 24;
    localparam int VT = 7;
    localparam int FT = HT * VT;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [1:0] psel;

    logic       hs, vs, de, fs;
    logic [7:0] r, g, b;
    logic       hs_n, vs_n, de_n, fs_n;
    logic [7:0] r_n, g_n, b_n;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    video_timing_gen #(
        .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(4),  .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HS_POL(1'b1), .VS_POL(1'b1)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .pattern_sel(psel),
        .HSync(hs), .VSync(vs), .DataEnable(de),
        .Red(r), .Green(g), .Blue(b), .frame_start(fs)
    );

    video_timing_gen #(
        .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(4),  .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HS_POL(1'b0), .VS_POL(1'b0)
    ) dut_n (
        .clk(clk), .rst(rst), .en(en), .pattern_sel(psel),
        .HSync(hs_n), .VSync(vs_n), .DataEnable(de_n),
        .Red(r_n), .Green(g_n), .Blue(b_n), .frame_start(fs_n)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [23:0] bar_colour(input int h);
        case (h / 2)
            0: return 24'hFFFFFF;
            1: return 24'hFFFF00;
            2: return 24'h00FFFF;
            3: return 24'h00FF00;
            4: return 24'hFF00FF;
            5: return 24'hFF0000;
            6: return 24'h0000FF;
            default: return 24'h000000;
        endcase
    endfunction

    task automatic step();
        @(negedge clk);
    endtask

    task automatic chk_idle(input string tag);
        check({tag, "_hs"},  {31'd0, hs}, 32'd0);
        check({tag, "_vs"},  {31'd0, vs}, 32'd0);
        check({tag, "_de"},  {31'd0, de}, 32'd0);
        check({tag, "_fs"},  {31'd0, fs}, 32'd0);
        check({tag, "_rgb"}, {8'd0, r, g, b}, 32'd0);
        check({tag, "_hs_n"}, {31'd0, hs_n}, 32'd1);
        check({tag, "_vs_n"}, {31'd0, vs_n}, 32'd1);
    endtask

    // Expected outputs for the pixel at (h,v) on this 16/2/3/3 x 4/1/1/1 raster.
    task automatic chk_pix(input string tag, input int h, input int v, input logic [1:0] pat);
        logic        e_de, e_hs, e_vs, e_fs;
        logic [23:0] e_rgb;
        logic [7:0]  hb;
        e_de = (h < 16) && (v < 4);
        e_hs = (h >= 18) && (h <= 20);
        e_vs = (v == 5);
        e_fs = (h == 0) && (v == 0);
        hb   = 8'(h);
        case (pat)
            2'b00: e_rgb = bar_colour(h);
            2'b01: e_rgb = {hb, hb, hb};
            2'b10: e_rgb = 24'h000000;
            default: e_rgb = ((h % 32 == 0) || (v % 32 == 0)) ? 24'hFFFFFF : 24'h000000;
        endcase
        if (!e_de) e_rgb = 24'h000000;
        check({tag, "_de"},  {31'd0, de}, {31'd0, e_de});
        check({tag, "_hs"},  {31'd0, hs}, {31'd0, e_hs});
        check({tag, "_vs"},  {31'd0, vs}, {31'd0, e_vs});
        check({tag, "_fs"},  {31'd0, fs}, {31'd0, e_fs});
        check({tag, "_rgb"}, {8'd0, r, g, b}, {8'd0, e_rgb});
        check({tag, "_hs_n"}, {31'd0, hs_n}, {31'd0, ~e_hs});
        check({tag, "_vs_n"}, {31'd0, vs_n}, {31'd0, ~e_vs});
        check({tag, "_fs_n"}, {31'd0, fs_n}, {31'd0, e_fs});
    endtask

    initial begin
        int last_fs, n_fs, n_hs, n_vs, de_rise;
        logic de_prev, hs_prev;

        rst  = 1'b1;
        en   = 1'b0;
        psel = 2'b00;
        repeat (3) step();
        chk_idle("reset");

        // Bars from the first enabled edge, then three free-running frames
        rst = 1'b0;
        en  = 1'b1;
        last_fs = -1; n_fs = 0; n_hs = 0; n_vs = 0; de_rise = 0;
        de_prev = 1'b0; hs_prev = 1'b0;
        for (int c = 0; c < 3 * FT; c++) begin
            step();
            chk_pix("run", c % HT, (c / HT) % VT, 2'b00);
            if (fs) begin
                if (last_fs >= 0) check("fs_period", 32'(c - last_fs), 32'(FT));
                last_fs = c;
                n_fs++;
            end
            if (de && !de_prev) de_rise = c;
            if (hs && !hs_prev && ((c / HT) % VT) < 4)
                check("hs_after_de", 32'(c - de_rise), 32'd18);
            de_prev = de;
            hs_prev = hs;
            n_hs += int'(hs);
            n_vs += int'(vs);
        end
        check("fs_count",  32'(n_fs), 32'd3);
        check("hs_clocks", 32'(n_hs), 32'd63);
        check("vs_clocks", 32'(n_vs), 32'd72);

        // Mid-frame pattern change waits for the next frame
        for (int c = 0; c < FT; c++) begin
            step();
            chk_pix("bars_hold", c % HT, c / HT, 2'b00);
            if (c == 30) psel = 2'b01;
        end
        for (int c = 0; c < 2 * HT + 6; c++) begin
            step();
            chk_pix("grad", c % HT, c / HT, 2'b01);
        end
        check("grad_h5", {8'd0, r, g, b}, 32'h00050505);

        // Drop enable mid-line 2; the new selection is taken at restart
        en   = 1'b0;
        psel = 2'b11;
        for (int i = 0; i < 10; i++) begin
            step();
            chk_idle("en_low");
        end
        en = 1'b1;
        for (int c = 0; c < 20; c++) begin
            step();
            chk_pix("reen", c, 0, 2'b11);
        end
        check("hs_before_rst", {31'd0, hs}, 32'd1);

        // Asynchronous reset in the middle of HSync
        #2 rst = 1'b1;
        #1;
        check("async_hs",   {31'd0, hs},   32'd0);
        check("async_de",   {31'd0, de},   32'd0);
        check("async_hs_n", {31'd0, hs_n}, 32'd1);
        check("async_rgb",  {8'd0, r, g, b}, 32'd0);
        step();
        chk_idle("in_reset");
        rst  = 1'b0;
        psel = 2'b00;
        for (int c = 0; c < HT + 2; c++) begin
            step();
            chk_pix("recover", c % HT, c / HT, 2'b00);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded its time budget");
        $fatal(1);
    end

endmodule
